fir4_chan_sched: RTL and testbench

Shared-datapath scheduler for the 4-tap moving-sum FIR. It time-multiplexes one 4-tap unsigned sum engine among NCH input channels. Each channel keeps its own 3-sample history, and a round-robin arbiter grants at most one channel per cycle. Each granted sample yields one registered output: the sum of that sample and its channel's three previous samples, tagged with the channel number. The block sits between the per-channel sample sources and the downstream FIR result consumer.

---
 rtl/fir4_chan_sched_if.sv | 17 +
 rtl/fir4_chan_sched.sv | 85 ++++++++
 tb/tb_fir4_chan_sched.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fir4_chan_sched_if.sv
// fir4_chan_sched_if: per-channel sample inputs and tagged result output of the FIR scheduler
interface fir4_chan_sched_if #(parameter int W = 16, parameter int NCH = 4);
  localparam int CW = $clog2(NCH);
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic [NCH-1:0]   clr;
  logic [NCH*W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_warm;
  logic [W+1:0]     out_sum;
  logic [CW-1:0]    out_ch;
  modport master(output in_valid, in_data, clr, out_ready,
                 input  in_ready, out_valid, out_sum, out_ch, out_warm);
  modport slave (input  in_valid, in_data, clr, out_ready,
                 output in_ready, out_valid, out_sum, out_ch, out_warm);
endinterface

// File: rtl/fir4_chan_sched.sv
// fir4_chan_sched: round-robin shares one 4-tap moving-sum engine among NCH channels
module fir4_chan_sched #(
  parameter int W   = 16,
  parameter int NCH = 4
) (
  input logic             clk,
  input logic             reset,
  fir4_chan_sched_if.slave bus
);
  localparam int CW = $clog2(NCH);
  logic [W-1:0]  h0_q [NCH];
  logic [W-1:0]  h0_d [NCH];
  logic [W-1:0]  h1_q [NCH];
  logic [W-1:0]  h1_d [NCH];
  logic [W-1:0]  h2_q [NCH];
  logic [W-1:0]  h2_d [NCH];
  logic [1:0]    fc_q [NCH];
  logic [1:0]    fc_d [NCH];
  logic [CW-1:0] p_q, p_d, ch_q, ch_d, g;
  logic          any, acc, clr_g, valid_q, valid_d, warm_q, warm_d;
  logic [W+1:0]  sum, sum_q, sum_d;
  logic [W-1:0]  smp;
  // scan downward so the last hit is the first candidate at or after p
  always_comb begin
    g   = '0;
    any = 1'b0;
    for (int k = NCH - 1; k >= 0; k--)
      if (bus.in_valid[(int'(p_q) + k) % NCH]) begin
        g   = CW'((int'(p_q) + k) % NCH);
        any = 1'b1;
      end
  end
  assign acc          = any & (~valid_q | bus.out_ready);
  assign bus.in_ready = acc ? NCH'(1) << g : '0;
  assign smp          = bus.in_data[int'(g)*W +: W];
  assign clr_g        = bus.clr[g];
  assign sum          = {2'b0, smp} + (clr_g ? '0 : {2'b0, h0_q[g]} + {2'b0, h1_q[g]} + {2'b0, h2_q[g]});
  // clears land first so a same-cycle accept shifts into an empty history
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      h0_d[i] = bus.clr[i] ? '0 : h0_q[i];
      h1_d[i] = bus.clr[i] ? '0 : h1_q[i];
      h2_d[i] = bus.clr[i] ? '0 : h2_q[i];
      fc_d[i] = bus.clr[i] ? '0 : fc_q[i];
    end
    if (acc) begin
      h2_d[g] = h1_d[g];
      h1_d[g] = h0_d[g];
      h0_d[g] = smp;
      fc_d[g] = fc_d[g] == 2'd3 ? 2'd3 : fc_d[g] + 2'd1;
    end
    valid_d = acc | (valid_q & ~bus.out_ready);
    sum_d   = acc ? sum : sum_q;
    ch_d    = acc ? g : ch_q;
    warm_d  = acc ? (fc_q[g] == 2'd3) & ~clr_g : warm_q;
    p_d     = acc ? (int'(g) == NCH - 1 ? '0 : g + 1'b1) : p_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      h0_q    <= '{default: '0};
      h1_q    <= '{default: '0};
      h2_q    <= '{default: '0};
      fc_q    <= '{default: '0};
      p_q     <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      ch_q    <= '0;
      warm_q  <= 1'b0;
    end else begin
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      fc_q    <= fc_d;
      p_q     <= p_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      ch_q    <= ch_d;
      warm_q  <= warm_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_warm  = warm_q;
endmodule

// File: tb/tb_fir4_chan_sched.sv
// tb_fir4_chan_sched: directed plan cases plus random traffic against a queue-based model
module tb_fir4_chan_sched;
  localparam int W = 16, NCH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int nvec = 0, nerr = 0;
  fir4_chan_sched_if #(.W(W), .NCH(NCH)) bus();
  fir4_chan_sched #(.W(W), .NCH(NCH)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: newest-first sample queue per channel, plus the output register contents
  int unsigned hist [NCH][$];
  int  m_p = 0, m_sum = 0, m_ch = 0;
  bit  m_v = 0, m_warm = 0;
  always begin : model_p
    bit rst, ordy, acc;
    logic [NCH-1:0] cl;
    int g, s, tot;
    @(negedge clk);
    rst  = reset;
    ordy = bus.out_ready;
    cl   = bus.clr;
    acc  = 0;
    g    = 0;
    s    = 0;
    if (!rst) begin
      for (int k = 0; k < NCH; k++)
        if (!acc && bus.in_valid[(m_p + k) % NCH]) begin
          g   = (m_p + k) % NCH;
          acc = 1;
        end
      acc = acc && (!m_v || ordy);
      s   = int'(bus.in_data[g*W +: W]);
      chk("in_ready", 32'(bus.in_ready), acc ? 32'(1) << g : 32'd0);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_p = 0; m_v = 0; m_sum = 0; m_ch = 0; m_warm = 0;
      for (int i = 0; i < NCH; i++) hist[i].delete();
    end else begin
      for (int i = 0; i < NCH; i++) if (cl[i]) hist[i].delete();
      if (acc) begin
        tot = s;
        foreach (hist[g][j]) tot += int'(hist[g][j]);
        m_sum  = tot;
        m_warm = hist[g].size() == 3;
        m_ch   = g;
        m_v    = 1;
        m_p    = (g + 1) % NCH;
        hist[g].push_front(s);
        if (hist[g].size() > 3) void'(hist[g].pop_back());
      end else if (m_v && ordy) m_v = 0;
    end
    chk("out_valid", 32'(bus.out_valid), 32'(m_v));
    chk("out_sum",   32'(bus.out_sum),   m_sum);
    chk("out_ch",    32'(bus.out_ch),    m_ch);
    chk("out_warm",  32'(bus.out_warm),  32'(m_warm));
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int ch, input int v);
    bus.in_data[ch*W +: W] = W'(v);
  endtask
  task automatic idle();
    bus.in_valid  = '0;
    bus.clr       = '0;
    bus.out_ready = 1'b1;
  endtask
  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  int ws [5] = '{1, 3, 6, 10, 14};
  bit ww [5] = '{0, 0, 0, 1, 1};
  initial begin
    bus.in_data = '0;
    idle();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_sum",   32'(bus.out_sum),   0);
    chk("rst_ch",    32'(bus.out_ch),    0);
    chk("rst_warm",  32'(bus.out_warm),  0);
    bus.in_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      put(0, i + 1);
      step();
      chk("wu_sum",   32'(bus.out_sum),   ws[i]);
      chk("wu_warm",  32'(bus.out_warm),  32'(ww[i]));
      chk("wu_ch",    32'(bus.out_ch),    0);
      chk("wu_valid", 32'(bus.out_valid), 1);
    end
    bus.in_valid = '0;
    step();
    chk("wu_drain", 32'(bus.out_valid), 0);
    do_reset();
    for (int i = 0; i < NCH; i++) put(i, 10 * (i + 1));
    bus.in_valid = '1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("rr_onehot", 32'($onehot(bus.in_ready)), 1);
      step();
      chk("rr_ch", 32'(bus.out_ch), k % NCH);
      if (k == 14) begin
        chk("rr_ch2_sum",  32'(bus.out_sum),  120);
        chk("rr_ch2_warm", 32'(bus.out_warm), 1);
      end
    end
    do_reset();
    bus.in_valid = 4'b0010;
    put(1, 7);
    step();
    chk("bp_first", 32'(bus.out_sum), 7);
    bus.out_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("bp_ready", 32'(bus.in_ready), 0);
      step();
      chk("bp_sum",   32'(bus.out_sum),   7);
      chk("bp_ch",    32'(bus.out_ch),    1);
      chk("bp_valid", 32'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_nobubble", 32'(bus.in_ready), 32'b0010);
    step();
    chk("bp_next", 32'(bus.out_sum), 14);
    do_reset();
    bus.in_valid = 4'b1000;
    put(3, 'hFFFF);
    repeat (4) step();
    chk("ovf_sum",  32'(bus.out_sum),  'h3FFFC);
    chk("ovf_warm", 32'(bus.out_warm), 1);
    chk("ovf_ch",   32'(bus.out_ch),   3);
    do_reset();
    bus.in_valid = 4'b0001;
    put(0, 7); step();
    put(0, 6); step();
    put(0, 5); step();
    put(0, 9);
    bus.clr = 4'b0001;
    step();
    bus.clr = '0;
    chk("clr_sum",  32'(bus.out_sum),  9);
    chk("clr_warm", 32'(bus.out_warm), 0);
    put(0, 1);
    step();
    chk("clr_next", 32'(bus.out_sum), 10);
    do_reset();
    bus.in_valid = 4'b0011;
    put(0, 3);
    put(1, 8);
    repeat (3) step();
    bus.in_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_valid", 32'(bus.out_valid), 0);
    bus.in_valid = '1;
    put(0, 4);
    step();
    chk("mid_ch",  32'(bus.out_ch),  0);
    chk("mid_sum", 32'(bus.out_sum), 4);
    repeat (800) begin
      reset = $urandom_range(0, 99) == 0;
      for (int i = 0; i < NCH; i++) begin
        bus.in_valid[i] = $urandom_range(0, 99) < 60;
        bus.clr[i]      = $urandom_range(0, 29) == 0;
        put(i, $urandom_range(0, 7) == 0 ? 'hFFFF : int'($urandom_range(0, 'hFFFF)));
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    reset = 1'b0;
    idle();
    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
